// File: rtl/cpu_pkg.sv
// Datapath constants shared by the destination-select, register-file and write-back logic.
// No logic here: widths, register count and the hardwired-zero register index.
package cpu_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/dec5_32.sv
// One-hot address decoder with enable; purely combinational, no handshake.
// With en_i low the output is all-zero regardless of addr_i, so an unknown address cannot leak through.
module dec5_32 #(
  parameter int ADDR_W  = 5,
  parameter int NUM_OUT = 2 ** ADDR_W
) (
  input  logic [ADDR_W-1:0]  addr_i,
  input  logic               en_i,
  output logic [NUM_OUT-1:0] dec_o
);

  always_comb begin
    dec_o = '0;
    if (en_i) begin
      dec_o[addr_i] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_file_wb.sv
// Register file: 2 combinational read ports with write-to-read bypass, 1 write port on rising Clk.
// Zero-cycle reads; no backpressure; register 0 is hardwired to zero; async active-low reset clears all.
module reg_file_wb #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  input  logic [ADDR_W-1:0] W,
  input  logic              WE,
  input  logic [DATA_W-1:0] Din,
  output logic [DATA_W-1:0] DoutA,
  output logic [DATA_W-1:0] DoutB
);

  import cpu_pkg::*;

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0]  wr_dec;
  logic [DEPTH-1:0]  wr_onehot;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];

  dec5_32 #(
    .ADDR_W  (ADDR_W),
    .NUM_OUT (DEPTH)
  ) u_wr_dec (
    .addr_i (W),
    .en_i   (WE),
    .dec_o  (wr_dec)
  );

  // Bit 0 masked so register 0 can never be loaded.
  assign wr_onehot = wr_dec & {{(DEPTH-1){1'b1}}, 1'b0};

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = wr_onehot[i] ? Din : regs_q[i];
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Reset forces zero even when Din would otherwise be bypassed.
  always_comb begin
    DoutA = '0;
    if (Rst_n && (RA != ADDR_W'(REG_ZERO))) begin
      DoutA = (WE && (W == RA)) ? Din : regs_q[RA];
    end
  end

  always_comb begin
    DoutB = '0;
    if (Rst_n && (RB != ADDR_W'(REG_ZERO))) begin
      DoutB = (WE && (W == RB)) ? Din : regs_q[RB];
    end
  end

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed self-checking bench for reg_file_wb.
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 time unit after each input change.
module tb_reg_file_wb;

  logic        Clk;
  logic        Rst_n;
  logic [4:0]  RA;
  logic [4:0]  RB;
  logic [4:0]  W;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] DoutA;
  logic [31:0] DoutB;

  int compared;
  int mismatched;

  reg_file_wb dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .RA    (RA),
    .RB    (RB),
    .W     (W),
    .WE    (WE),
    .Din   (Din),
    .DoutA (DoutA),
    .DoutB (DoutB)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
    W = addr; Din = data; WE = 1'b1;
    tick();
    WE = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    Rst_n = 1'b0; RA = 5'd5; RB = 5'd31; W = 5'd0; WE = 1'b0; Din = '0;

    // Reset holds outputs at zero
    #3;
    check("rst_doutA", DoutA, 32'h0);
    check("rst_doutB", DoutB, 32'h0);
    tick(); tick();
    Rst_n = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) begin
      RA = 5'(i); RB = 5'(31 - i);
      #1;
      check($sformatf("post_rst_A[%0d]", i), DoutA, 32'h0);
      check($sformatf("post_rst_B[%0d]", 31 - i), DoutB, 32'h0);
    end

    // Basic write then read
    write_reg(5'd5, 32'hDEADBEEF);
    RA = 5'd5; RB = 5'd6;
    #1;
    check("basic_rd5", DoutA, 32'hDEADBEEF);
    check("basic_rd6", DoutB, 32'h0);

    // Register 0 ignores writes and never bypasses
    W = 5'd0; Din = 32'hFFFFFFFF; WE = 1'b1; RA = 5'd0; RB = 5'd0;
    #1;
    check("r0_bypass_A", DoutA, 32'h0);
    check("r0_bypass_B", DoutB, 32'h0);
    tick();
    WE = 1'b0;
    #1;
    check("r0_after_edge", DoutA, 32'h0);

    // Bypass on both ports, then stored value after the edge
    write_reg(5'd9, 32'h11111111);
    RA = 5'd9; RB = 5'd9;
    #1;
    check("r9_stored", DoutA, 32'h11111111);
    W = 5'd9; Din = 32'h22222222; WE = 1'b1;
    #1;
    check("bypass_A", DoutA, 32'h22222222);
    check("bypass_B", DoutB, 32'h22222222);
    tick();
    WE = 1'b0; Din = 32'h33333333;
    #1;
    check("bypass_after_A", DoutA, 32'h22222222);
    check("bypass_after_B", DoutB, 32'h22222222);

    // Bypass on one port only
    RA = 5'd9; RB = 5'd5; W = 5'd5; Din = 32'h0BADF00D; WE = 1'b1;
    #1;
    check("split_bypass_A", DoutA, 32'h22222222);
    check("split_bypass_B", DoutB, 32'h0BADF00D);
    WE = 1'b0;
    #1;
    check("split_nowe_B", DoutB, 32'hDEADBEEF);

    // Write enable gating, including unknown write address
    write_reg(5'd3, 32'hA5A5A5A5);
    W = 5'd3; Din = 32'h0; WE = 1'b0;
    repeat (4) tick();
    RA = 5'd3; RB = 5'd5;
    #1;
    check("we_gate_r3", DoutA, 32'hA5A5A5A5);
    W = 'x; Din = 32'h12345678;
    tick();
    check("wx_r3", DoutA, 32'hA5A5A5A5);
    check("wx_r5", DoutB, 32'hDEADBEEF);

    // Fill 1..31 with their index
    for (int i = 1; i < 32; i++) begin
      write_reg(5'(i), 32'(i));
    end
    RA = 5'd7; RB = 5'd31;
    #1;
    check("fill_r7", DoutA, 32'd7);
    check("fill_r31", DoutB, 32'd31);
    RA = 5'd18; RB = 5'd1;
    #1;
    check("fill_r18", DoutA, 32'd18);
    check("fill_r1", DoutB, 32'd1);

    // Async reset between edges while a write is pending
    RA = 5'd7; RB = 5'd9; W = 5'd7; Din = 32'hFFFF0000; WE = 1'b1;
    #1;
    check("pre_rst_bypass", DoutA, 32'hFFFF0000);
    #1;
    Rst_n = 1'b0;
    #1;
    check("async_rst_A", DoutA, 32'h0);
    check("async_rst_B", DoutB, 32'h0);
    tick();
    check("rst_over_write_A", DoutA, 32'h0);
    WE = 1'b0;
    tick();
    Rst_n = 1'b1;
    #1;
    check("release_r7", DoutA, 32'h0);
    check("release_r9", DoutB, 32'h0);
    RB = 5'd31;
    #1;
    check("release_r31", DoutB, 32'h0);

    // First write after release lands on the next edge
    W = 5'd12; Din = 32'h00C0FFEE; WE = 1'b1; RA = 5'd12; RB = 5'd13;
    tick();
    WE = 1'b0;
    #1;
    check("post_rel_r12", DoutA, 32'h00C0FFEE);
    check("post_rel_r13", DoutB, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
